acs_pipe_array: RTL

//  Parametrised systolic add-compare-select array for the 4-state (K=3, rate 1/2, G=7,5 octal) Viterbi decoder.

---
 rtl/acs_pipe_array.sv | 137 +++++++++++++
 1 files changed

// File: rtl/acs_pipe_array.sv
// Systolic add-compare-select array for the 4-state K=3 (7,5) Viterbi decoder.
// One block of DEPTH symbol pairs enters per cycle; its metrics and survivors leave DEPTH cycles later.
module acs_pipe_array #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PM_W        = 7,
  parameter bit          START_KNOWN = 1'b1,
  parameter int unsigned INIT        = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [2*DEPTH-1:0]   sym_in,
  output logic                 out_valid,
  output logic [4*PM_W-1:0]    pm_out,
  output logic [4*DEPTH-1:0]   path_out,
  output logic [1:0]           best_state,
  output logic [DEPTH-1:0]     best_path
);

  // Symbol k owns a k-entry delay chain starting at bit k*(k-1).
  localparam int unsigned SkewW   = DEPTH * (DEPTH - 1);
  // Stage k keeps k+1 survivor bits per state, packed from bit 2*k*(k+1).
  localparam int unsigned PathW   = 2 * DEPTH * (DEPTH + 1);
  localparam int unsigned LastOff = 2 * (DEPTH - 1) * DEPTH;
  localparam int unsigned SumW    = PM_W + 1;
  localparam logic [PM_W-1:0] SeedPm = START_KNOWN ? PM_W'(INIT) : '0;

  function automatic logic [1:0] branch_metric(logic [1:0] sym, logic u, logic p1, logic p0);
    logic [1:0] diff;
    diff = sym ^ {u ^ p1 ^ p0, u ^ p0};
    return {diff[1] & diff[0], diff[1] ^ diff[0]};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] pm, logic [1:0] bm);
    logic [PM_W:0] sum;
    sum = {1'b0, pm} + SumW'(bm);
    return sum[PM_W] ? '1 : sum[PM_W-1:0];
  endfunction

  logic [SkewW-1:0]                  skew_q, skew_d;
  logic [DEPTH-1:0][3:0][PM_W-1:0]   pm_q, pm_d;
  logic [PathW-1:0]                  path_q, path_d;
  logic [DEPTH-1:0]                  vld_q, vld_d;

  always_comb begin
    skew_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      skew_d[k*(k-1) +: 2] = sym_in[2*k +: 2];
      for (int j = 1; j < k; j++) begin
        skew_d[k*(k-1) + 2*j +: 2] = skew_q[k*(k-1) + 2*(j-1) +: 2];
      end
    end
  end

  assign vld_d = {vld_q[DEPTH-2:0], in_valid};

  logic [3:0][PM_W-1:0] pm_prev, pm_sel;
  logic [1:0]           sym_k;
  logic [3:0]           sel_odd;
  logic [PM_W-1:0]      cand_even, cand_odd;
  logic                 norm;
  int                   kp, pred, cur_off, prev_off;

  always_comb begin
    pm_d      = '0;
    path_d    = '0;
    pm_prev   = '0;
    pm_sel    = '0;
    sym_k     = '0;
    sel_odd   = '0;
    cand_even = '0;
    cand_odd  = '0;
    norm      = 1'b0;
    kp        = 0;
    pred      = 0;
    cur_off   = 0;
    prev_off  = 0;
    for (int k = 0; k < DEPTH; k++) begin
      kp = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        sym_k   = sym_in[1:0];
        pm_prev = {SeedPm, SeedPm, SeedPm, {PM_W{1'b0}}};
      end else begin
        sym_k   = skew_q[kp*(kp+3) +: 2];
        pm_prev = pm_q[kp];
      end
      // New state n = {u, p1}; its predecessors are {p1, 0} and {p1, 1}.
      for (int n = 0; n < 4; n++) begin
        cand_even  = sat_add(pm_prev[{n[0], 1'b0}], branch_metric(sym_k, n[1], n[0], 1'b0));
        cand_odd   = sat_add(pm_prev[{n[0], 1'b1}], branch_metric(sym_k, n[1], n[0], 1'b1));
        sel_odd[n] = cand_odd < cand_even;
        pm_sel[n]  = sel_odd[n] ? cand_odd : cand_even;
      end
      norm = pm_sel[0][PM_W-1] & pm_sel[1][PM_W-1] & pm_sel[2][PM_W-1] & pm_sel[3][PM_W-1];
      for (int n = 0; n < 4; n++) begin
        pm_d[k][n] = norm ? {1'b0, pm_sel[n][PM_W-2:0]} : pm_sel[n];
      end
      cur_off  = 2 * k * (k + 1);
      prev_off = 2 * kp * (kp + 1);
      for (int n = 0; n < 4; n++) begin
        pred = int'({n[0], sel_odd[n]});
        path_d[cur_off + n*(k+1)] = n[1];
        for (int b = 1; b <= k; b++) begin
          path_d[cur_off + n*(k+1) + b] = path_q[prev_off + pred*k + b - 1];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skew_q <= '0;
      pm_q   <= '0;
      path_q <= '0;
      vld_q  <= '0;
    end else begin
      skew_q <= skew_d;
      pm_q   <= pm_d;
      path_q <= path_d;
      vld_q  <= vld_d;
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign pm_out    = pm_q[DEPTH-1];
  assign path_out  = path_q[LastOff +: 4*DEPTH];

  // Strict compare keeps the lowest state index on a metric tie.
  always_comb begin
    best_state = 2'd0;
    for (int s = 1; s < 4; s++) begin
      if (pm_q[DEPTH-1][s] < pm_q[DEPTH-1][best_state]) best_state = 2'(s);
    end
    best_path = path_q[LastOff + int'(best_state)*DEPTH +: DEPTH];
  end

endmodule
